// File: rtl/sprite_anim_ctrl.sv
// Per-player animation sequencer: latches action requests between VGA frames,
// runs the action FSM and drives the sprite ROM frame offset.
module sprite_anim_ctrl #(
    parameter int FRAME_WORDS     = 4096,
    parameter int ADDR_W          = 16,
    parameter int TICKS_PER_FRAME = 4,
    parameter int IDLE_BASE       = 0,
    parameter int IDLE_LEN        = 2,
    parameter int WALK_BASE       = 2,
    parameter int WALK_LEN        = 4,
    parameter int PUNCH_BASE      = 6,
    parameter int PUNCH_LEN       = 3,
    parameter int KICK_BASE       = 9,
    parameter int KICK_LEN        = 3,
    parameter int HIT_BASE        = 12,
    parameter int HIT_LEN         = 2,
    parameter int ACTIVE_IDX      = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              frame_tick,
    input  logic              move_left,
    input  logic              move_right,
    input  logic              punch,
    input  logic              kick,
    input  logic              hit,
    output logic [ADDR_W-1:0] addr_offset,
    output logic [2:0]        anim_state,
    output logic              attack_active,
    output logic              busy
);

    localparam int IDX_W = 8;
    localparam logic [ADDR_W-1:0] RST_ADDR = ADDR_W'(IDLE_BASE * FRAME_WORDS);

    if ((HIT_BASE + HIT_LEN) * FRAME_WORDS > 2 ** ADDR_W) begin : g_addr_chk
        $error("sprite_anim_ctrl: frame offsets do not fit in ADDR_W");
    end
    if (TICKS_PER_FRAME < 1 || TICKS_PER_FRAME > 15) begin : g_tpf_chk
        $error("sprite_anim_ctrl: TICKS_PER_FRAME out of range 1..15");
    end

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WALK  = 3'd1,
        ST_PUNCH = 3'd2,
        ST_KICK  = 3'd3,
        ST_HIT   = 3'd4
    } state_e;

    function automatic logic [IDX_W-1:0] base_of(input state_e s);
        case (s)
            ST_IDLE:  base_of = IDX_W'(IDLE_BASE);
            ST_WALK:  base_of = IDX_W'(WALK_BASE);
            ST_PUNCH: base_of = IDX_W'(PUNCH_BASE);
            ST_KICK:  base_of = IDX_W'(KICK_BASE);
            ST_HIT:   base_of = IDX_W'(HIT_BASE);
            default:  base_of = IDX_W'(IDLE_BASE);
        endcase
    endfunction

    function automatic logic [IDX_W-1:0] len_of(input state_e s);
        case (s)
            ST_IDLE:  len_of = IDX_W'(IDLE_LEN);
            ST_WALK:  len_of = IDX_W'(WALK_LEN);
            ST_PUNCH: len_of = IDX_W'(PUNCH_LEN);
            ST_KICK:  len_of = IDX_W'(KICK_LEN);
            ST_HIT:   len_of = IDX_W'(HIT_LEN);
            default:  len_of = IDX_W'(IDLE_LEN);
        endcase
    endfunction

    state_e             state_q, state_d, sel_s;
    logic [IDX_W-1:0]   frame_q, frame_d, adv_frame_s;
    logic [3:0]         hold_q, hold_d, adv_hold_s;
    logic               pend_punch_q, pend_punch_d;
    logic               pend_kick_q, pend_kick_d;
    logic               pend_hit_q, pend_hit_d;
    logic               punch_prev_q, kick_prev_q;
    logic [ADDR_W-1:0]  addr_d;
    logic               attack_d, busy_d;
    logic [31:0]        prod_s;
    logic               locked_s, hold_wrap_s, last_frame_s, complete_s;
    logic               clr_all_s, clr_hit_s;

    // Next-state evaluation: state only moves on frame_tick; requests are captured every cycle.
    always_comb begin
        state_d      = state_q;
        frame_d      = frame_q;
        hold_d       = hold_q;
        clr_all_s    = 1'b0;
        clr_hit_s    = 1'b0;
        locked_s     = (state_q == ST_PUNCH) || (state_q == ST_KICK) || (state_q == ST_HIT);
        hold_wrap_s  = (hold_q == 4'(TICKS_PER_FRAME - 1));
        last_frame_s = (frame_q == base_of(state_q) + len_of(state_q) - 8'd1);
        complete_s   = locked_s && hold_wrap_s && last_frame_s;

        if (hold_wrap_s) begin
            adv_hold_s  = 4'd0;
            adv_frame_s = last_frame_s ? base_of(state_q) : frame_q + 8'd1;
        end else begin
            adv_hold_s  = hold_q + 4'd1;
            adv_frame_s = frame_q;
        end

        if (pend_hit_q) begin
            sel_s = ST_HIT;
        end else if (pend_punch_q) begin
            sel_s = ST_PUNCH;
        end else if (pend_kick_q) begin
            sel_s = ST_KICK;
        end else if (move_left ^ move_right) begin
            sel_s = ST_WALK;
        end else begin
            sel_s = ST_IDLE;
        end

        if (frame_tick) begin
            if (!locked_s || complete_s) begin
                clr_all_s = 1'b1;
                // Unlocked reselection of the same loop keeps its phase.
                if (!locked_s && (sel_s == state_q)) begin
                    frame_d = adv_frame_s;
                    hold_d  = adv_hold_s;
                end else begin
                    state_d = sel_s;
                    frame_d = base_of(sel_s);
                    hold_d  = 4'd0;
                end
            end else if (pend_hit_q) begin
                clr_hit_s = 1'b1;
                state_d   = ST_HIT;
                frame_d   = IDX_W'(HIT_BASE);
                hold_d    = 4'd0;
            end else begin
                frame_d = adv_frame_s;
                hold_d  = adv_hold_s;
            end
        end else begin
            state_d = state_q;
        end

        pend_punch_d = (pend_punch_q & ~clr_all_s) | (punch & ~punch_prev_q);
        pend_kick_d  = (pend_kick_q & ~clr_all_s) | (kick & ~kick_prev_q);
        pend_hit_d   = (pend_hit_q & ~(clr_all_s | clr_hit_s)) | hit;

        prod_s   = 32'(frame_d) * 32'(FRAME_WORDS);
        addr_d   = prod_s[ADDR_W-1:0];
        attack_d = ((state_d == ST_PUNCH) && (frame_d == IDX_W'(PUNCH_BASE + ACTIVE_IDX))) ||
                   ((state_d == ST_KICK)  && (frame_d == IDX_W'(KICK_BASE + ACTIVE_IDX)));
        busy_d   = (state_d == ST_PUNCH) || (state_d == ST_KICK) || (state_d == ST_HIT);
    end

    // State, pending-request and registered-output flops.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            frame_q       <= IDX_W'(IDLE_BASE);
            hold_q        <= 4'd0;
            pend_punch_q  <= 1'b0;
            pend_kick_q   <= 1'b0;
            pend_hit_q    <= 1'b0;
            punch_prev_q  <= 1'b0;
            kick_prev_q   <= 1'b0;
            addr_offset   <= RST_ADDR;
            anim_state    <= 3'd0;
            attack_active <= 1'b0;
            busy          <= 1'b0;
        end else begin
            state_q       <= state_d;
            frame_q       <= frame_d;
            hold_q        <= hold_d;
            pend_punch_q  <= pend_punch_d;
            pend_kick_q   <= pend_kick_d;
            pend_hit_q    <= pend_hit_d;
            punch_prev_q  <= punch;
            kick_prev_q   <= kick;
            addr_offset   <= addr_d;
            anim_state    <= state_d;
            attack_active <= attack_d;
            busy          <= busy_d;
        end
    end

endmodule
